// File: rtl/simple_stream_packer_if.sv
// Stream bundle between the narrow producer, the packer and the wide consumer.
// slave = packer view, master = surrounding environment view.
interface simple_stream_packer_if #(
  parameter int unsigned SpatPar   = 4,
  parameter int unsigned DataWidth = 64
);
  logic [DataWidth-1:0]         data_i;
  logic                         data_valid_i;
  logic                         data_last_i;
  logic                         data_ready_o;
  logic [SpatPar*DataWidth-1:0] data_o;
  logic [SpatPar-1:0]           data_strb_o;
  logic                         data_last_o;
  logic                         data_valid_o;
  logic                         data_ready_i;

  modport slave (
    input  data_i, data_valid_i, data_last_i, data_ready_i,
    output data_ready_o, data_o, data_strb_o, data_last_o, data_valid_o
  );

  modport master (
    output data_i, data_valid_i, data_last_i, data_ready_i,
    input  data_ready_o, data_o, data_strb_o, data_last_o, data_valid_o
  );
endinterface

// File: rtl/simple_stream_packer.sv
// Packs SpatPar narrow words (lane 0 first) into one wide beat; early close via last.
// Optional output-beat counter enabled by defining SIMPLE_STREAM_PACKER_PERF_CNT_EN.
module simple_stream_packer #(
  parameter int unsigned SpatPar   = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  simple_stream_packer_if.slave bus,
  output logic [CntWidth-1:0]   beat_cnt_o
);

  localparam int unsigned LaneW = (SpatPar > 1) ? $clog2(SpatPar) : 1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } phase_e;

  phase_e                       state_q, state_d;
  logic [SpatPar*DataWidth-1:0] pack_q, pack_d;
  logic [SpatPar-1:0]           strb_q, strb_d;
  logic                         last_q, last_d;
  logic [LaneW-1:0]             lane_q, lane_d;

  logic ready;
  logic in_fire;
  logic out_fire;
  logic closing;

  // Ready depends only on the held phase and downstream ready, never on data_valid_i.
  assign ready    = (state_q == FILL) || bus.data_ready_i;
  assign in_fire  = bus.data_valid_i && ready;
  assign out_fire = (state_q == HOLD) && bus.data_ready_i;
  assign closing  = in_fire && ((lane_q == LaneW'(SpatPar - 1)) || bus.data_last_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pack_q <= '0;
      strb_q <= '0;
      last_q <= 1'b0;
      lane_q <= '0;
    end else begin
      pack_q <= pack_d;
      strb_q <= strb_d;
      last_q <= last_d;
      lane_q <= lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (closing) begin
      state_d = HOLD;
    end else if (out_fire) begin
      state_d = FILL;
    end
  end

  always_comb begin
    pack_d = pack_q;
    strb_d = strb_q;
    last_d = last_q;
    lane_d = lane_q;
    if (in_fire) begin
      // A word at lane 0 opens a fresh beat, so stale lanes are cleared first.
      if (lane_q == '0) begin
        pack_d = '0;
        strb_d = '0;
      end
      for (int unsigned k = 0; k < SpatPar; k++) begin
        if (LaneW'(k) == lane_q) begin
          pack_d[k*DataWidth +: DataWidth] = bus.data_i;
          strb_d[k]                        = 1'b1;
        end
      end
      if (closing) begin
        lane_d = '0;
        last_d = bus.data_last_i;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  always_comb begin
    bus.data_ready_o = ready;
    bus.data_valid_o = (state_q == HOLD);
    bus.data_o       = pack_q;
    bus.data_strb_o  = strb_q;
    bus.data_last_o  = last_q;
  end

`ifdef SIMPLE_STREAM_PACKER_PERF_CNT_EN
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_cnt_o = cnt_q;
`else
  assign beat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_simple_stream_packer.sv
// Scoreboard bench for simple_stream_packer: SpatPar=4, DataWidth=64, CntWidth=4.
module tb_simple_stream_packer;

  localparam int unsigned SP = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [SP*DW-1:0] data;
    logic [SP-1:0]    strb;
    logic             last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] beat_cnt;

  always #5 clk = ~clk;

  simple_stream_packer_if #(.SpatPar(SP), .DataWidth(DW)) bus ();

  simple_stream_packer #(.SpatPar(SP), .DataWidth(DW), .CntWidth(CW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .beat_cnt_o (beat_cnt)
  );

  beat_t       sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          beats_seen = 0;
  int          stalls = 0;
  logic [DW-1:0] m_lane[SP];
  logic [SP-1:0] m_strb;
  int unsigned   m_cnt = 0;

  // Scoreboard: compare every delivered beat against the expected queue.
  always @(negedge clk) begin : monitor
    beat_t exp_b;
    if (rst_n === 1'b1 && bus.data_valid_o === 1'b1 && bus.data_ready_i === 1'b1) begin
      tests++;
      beats_seen++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected: got data=%h strb=%b last=%b, required no beat",
                 bus.data_o, bus.data_strb_o, bus.data_last_o);
      end else begin
        exp_b = sb_q.pop_front();
        if ({bus.data_o, bus.data_strb_o, bus.data_last_o} !== exp_b) begin
          fails++;
          $display("FAIL beat_content: got data=%h strb=%b last=%b, required data=%h strb=%b last=%b",
                   bus.data_o, bus.data_strb_o, bus.data_last_o, exp_b.data, exp_b.strb, exp_b.last);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  task automatic model_clear();
    for (int k = 0; k < SP; k++) m_lane[k] = '0;
    m_strb = '0;
    m_cnt  = 0;
    sb_q.delete();
  endtask

  task automatic push(input logic [DW-1:0] w, input logic l);
    int    n = 0;
    beat_t b;
    bus.data_i       = w;
    bus.data_last_i  = l;
    bus.data_valid_i = 1'b1;
    @(negedge clk);
    while (bus.data_ready_o !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus.data_ready_o !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got data_ready_o=%b, required 1 within 64 cycles", bus.data_ready_o);
    end else begin
      if (n > 0) stalls++;
      if (m_cnt == 0) begin
        for (int k = 0; k < SP; k++) m_lane[k] = '0;
        m_strb = '0;
      end
      m_lane[m_cnt] = w;
      m_strb[m_cnt] = 1'b1;
      if (m_cnt == SP - 1 || l) begin
        for (int k = 0; k < SP; k++) b.data[k*DW +: DW] = m_lane[k];
        b.strb = m_strb;
        b.last = l;
        sb_q.push_back(b);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    bus.data_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || bus.data_valid_o === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d beats outstanding, required 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset(2);
    tests += 6;
    if (bus.data_valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b, required 0", bus.data_valid_o); end
    if (bus.data_strb_o !== 4'b0000) begin fails++; $display("FAIL rst_strb: got %b, required 0000", bus.data_strb_o); end
    if (bus.data_last_o !== 1'b0) begin fails++; $display("FAIL rst_last: got %b, required 0", bus.data_last_o); end
    if (bus.data_o !== '0) begin fails++; $display("FAIL rst_data: got %h, required 0", bus.data_o); end
    if (bus.data_ready_o !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b, required 1", bus.data_ready_o); end
    if (beat_cnt !== 4'd0) begin fails++; $display("FAIL rst_cnt: got %0d, required 0", beat_cnt); end
  endtask

  task automatic test_full_pack();
    logic [SP*DW-1:0] exp_d;
    exp_d = {64'h44, 64'h33, 64'h22, 64'h11};
    push(64'h11, 1'b0);
    push(64'h22, 1'b0);
    push(64'h33, 1'b0);
    tests++;
    if (bus.data_valid_o !== 1'b0) begin fails++; $display("FAIL full_early_valid: got %b, required 0", bus.data_valid_o); end
    push(64'h44, 1'b0);
    tests += 4;
    if (bus.data_valid_o !== 1'b1) begin fails++; $display("FAIL full_latency: got valid %b, required 1", bus.data_valid_o); end
    if (bus.data_o !== exp_d) begin fails++; $display("FAIL full_data: got %h, required %h", bus.data_o, exp_d); end
    if (bus.data_strb_o !== 4'b1111) begin fails++; $display("FAIL full_strb: got %b, required 1111", bus.data_strb_o); end
    if (bus.data_last_o !== 1'b0) begin fails++; $display("FAIL full_last: got %b, required 0", bus.data_last_o); end
    drain();
  endtask

  task automatic test_partial();
    logic [SP*DW-1:0] exp_d;
    push(64'hA, 1'b0);
    push(64'hB, 1'b1);
    exp_d = {64'h0, 64'h0, 64'hB, 64'hA};
    tests += 4;
    if (bus.data_valid_o !== 1'b1) begin fails++; $display("FAIL part_valid: got %b, required 1", bus.data_valid_o); end
    if (bus.data_o !== exp_d) begin fails++; $display("FAIL part_data: got %h, required %h", bus.data_o, exp_d); end
    if (bus.data_strb_o !== 4'b0011) begin fails++; $display("FAIL part_strb: got %b, required 0011", bus.data_strb_o); end
    if (bus.data_last_o !== 1'b1) begin fails++; $display("FAIL part_last: got %b, required 1", bus.data_last_o); end
    // Accepted in the same cycle the previous beat leaves; single-word beat.
    push(64'hC, 1'b1);
    exp_d = {64'h0, 64'h0, 64'h0, 64'hC};
    tests += 4;
    if (bus.data_valid_o !== 1'b1) begin fails++; $display("FAIL lane0_valid: got %b, required 1", bus.data_valid_o); end
    if (bus.data_o !== exp_d) begin fails++; $display("FAIL lane0_data: got %h, required %h", bus.data_o, exp_d); end
    if (bus.data_strb_o !== 4'b0001) begin fails++; $display("FAIL lane0_strb: got %b, required 0001", bus.data_strb_o); end
    if (bus.data_last_o !== 1'b1) begin fails++; $display("FAIL lane0_last: got %b, required 1", bus.data_last_o); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [SP*DW-1:0] exp_d;
    int s0;
    exp_d = {64'h4, 64'h3, 64'h2, 64'h1};
    bus.data_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) push(64'(i), 1'b0);
    bus.data_i       = 64'h5;
    bus.data_last_i  = 1'b0;
    bus.data_valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tests++;
      if ({bus.data_ready_o, bus.data_valid_o, bus.data_strb_o, bus.data_o} !== {1'b0, 1'b1, 4'b1111, exp_d}) begin
        fails++;
        $display("FAIL bp_hold: got ready=%b valid=%b strb=%b data=%h, required ready=0 valid=1 strb=1111 data=%h",
                 bus.data_ready_o, bus.data_valid_o, bus.data_strb_o, bus.data_o, exp_d);
      end
    end
    @(posedge clk);
    #1;
    bus.data_ready_i = 1'b1;
    s0 = stalls;
    push(64'h5, 1'b0);
    tests++;
    if (stalls != s0) begin fails++; $display("FAIL bp_release_accept: got %0d stall cycles, required 0", stalls - s0); end
    for (int i = 6; i <= 8; i++) push(64'(i), 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    int s0, b0;
    s0 = stalls;
    b0 = beats_seen;
    for (int i = 0; i < 12; i++) push(64'h100 + 64'(i), 1'b0);
    drain();
    tests += 2;
    if (stalls != s0) begin fails++; $display("FAIL stream_stalls: got %0d, required 0", stalls - s0); end
    if (beats_seen != b0 + 3) begin fails++; $display("FAIL stream_beats: got %0d, required 3", beats_seen - b0); end
  endtask

  task automatic test_reset_mid_beat();
    logic [SP*DW-1:0] exp_d;
    push(64'hAA, 1'b0);
    push(64'hBB, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    tests += 2;
    if (bus.data_valid_o !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b, required 0", bus.data_valid_o); end
    if (bus.data_strb_o !== 4'b0000) begin fails++; $display("FAIL midrst_strb: got %b, required 0000", bus.data_strb_o); end
    for (int i = 1; i <= 4; i++) push(64'hC0 + 64'(i), 1'b0);
    exp_d = {64'hC4, 64'hC3, 64'hC2, 64'hC1};
    tests += 2;
    if (bus.data_o !== exp_d) begin fails++; $display("FAIL midrst_data: got %h, required %h", bus.data_o, exp_d); end
    if (bus.data_strb_o !== 4'b1111) begin fails++; $display("FAIL midrst_beat_strb: got %b, required 1111", bus.data_strb_o); end
    drain();
  endtask

  task automatic test_counter();
    logic [CW-1:0] exp_c;
`ifdef SIMPLE_STREAM_PACKER_PERF_CNT_EN
    exp_c = 4'd1;
`else
    exp_c = 4'd0;
`endif
    do_reset(1);
    for (int i = 0; i < 17; i++) push(64'h900 + 64'(i), 1'b1);
    drain();
    tests++;
    if (beat_cnt !== exp_c) begin fails++; $display("FAIL cnt_wrap: got %0d, required %0d", beat_cnt, exp_c); end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.data_i       = '0;
    bus.data_valid_i = 1'b0;
    bus.data_last_i  = 1'b0;
    bus.data_ready_i = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_full_pack();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_beat();
    test_counter();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
